draw_sprite_anim: RTL and testbench

Parametrised successor to the fixed player-drawing stage. Overlays one animated, optionally mirrored and integer-scaled sprite onto the VGA stream. Pixels are fetched from an external synchronous sprite ROM, and a colour key gives transparency. Sits in the vga_if pipeline between background and HUD stages, one instance per on-screen character.

---
 rtl/draw_sprite_anim_if.sv | 13 +
 rtl/draw_sprite_anim.sv | 129 ++++++++++++
 tb/tb_draw_sprite_anim.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/draw_sprite_anim_if.sv
// VGA stream bundle: timing counters, sync/blank flags and 12-bit colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_anim.sv
// Overlays one animated, mirrorable, integer-scaled sprite from a synchronous ROM
// onto the VGA stream; colour key gives transparency, 2-cycle pass-through latency.
module draw_sprite_anim #(
  parameter int          SPRITE_W   = 32,
  parameter int          SPRITE_H   = 48,
  parameter int          FRAMES     = 4,
  parameter int          SCALE_LOG2 = 0,
  parameter int          FRAME_DIV  = 8,
  parameter logic [11:0] TRANSP_RGB = 12'hF0F,
  localparam int         AW = $clog2(SPRITE_W*SPRITE_H*FRAMES),
  localparam int         FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  vga_if.in             vga_in,
  vga_if.out            vga_out,
  input  logic [11:0]   xpos,
  input  logic [11:0]   ypos,
  input  logic          mirror,
  input  logic          anim_en,
  output logic [AW-1:0] rom_addr,
  input  logic [11:0]   rom_data,
  output logic          hit,
  output logic [FW-1:0] frame_idx
);
  localparam int DW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int CW   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int BOXW = SPRITE_W << SCALE_LOG2;
  localparam int BOXH = SPRITE_H << SCALE_LOG2;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t          s0, s1, s2;
  logic          in1, in2;
  logic          vb_q, vb_rise;
  logic [11:0]   xl, yl;
  logic          mir_l;
  logic [DW-1:0] div;
  logic [12:0]   dx, dy;
  logic          inbox;
  logic [CW-1:0] col, colm;
  logic [RW-1:0] row;
  logic [AW-1:0] addr_nxt;
  logic          blank2, opaque;

  always_comb begin
    s0 = '{hcount: vga_in.hcount, vcount: vga_in.vcount, hsync: vga_in.hsync,
           vsync: vga_in.vsync, hblnk: vga_in.hblnk, vblnk: vga_in.vblnk,
           rgb: vga_in.rgb};
  end

  assign vb_rise = vga_in.vblnk & ~vb_q;

  // 13-bit differences: bit 12 is the sign, so off-left/top never wraps into the box
  always_comb begin
    dx       = {2'b00, vga_in.hcount} - {1'b0, xl};
    dy       = {2'b00, vga_in.vcount} - {1'b0, yl};
    inbox    = !dx[12] && (dx < 13'(BOXW)) && !dy[12] && (dy < 13'(BOXH));
    col      = CW'(dx >> SCALE_LOG2);
    row      = RW'(dy >> SCALE_LOG2);
    colm     = mir_l ? (CW'(SPRITE_W-1) - col) : col;
    addr_nxt = AW'(frame_idx) * AW'(SPRITE_W*SPRITE_H) + AW'(row) * AW'(SPRITE_W) + AW'(colm);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      in1      <= 1'b0;
      in2      <= 1'b0;
      rom_addr <= '0;
    end else begin
      s1  <= s0;
      s2  <= s1;
      in1 <= inbox;
      in2 <= in1;
      if (inbox) rom_addr <= addr_nxt;
    end
  end

  // Position/mirror only change at vblank start so a frame never tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vb_q      <= 1'b0;
      xl        <= '0;
      yl        <= '0;
      mir_l     <= 1'b0;
      div       <= '0;
      frame_idx <= '0;
    end else begin
      vb_q <= vga_in.vblnk;
      if (vb_rise) begin
        xl    <= xpos;
        yl    <= ypos;
        mir_l <= mirror;
        if (anim_en) begin
          if (div == DW'(FRAME_DIV-1)) begin
            div       <= '0;
            frame_idx <= (frame_idx == FW'(FRAMES-1)) ? '0 : frame_idx + 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
      end
    end
  end

  // ROM data arrives alongside s2, so the colour mux is combinational on it
  assign blank2 = s2.hblnk | s2.vblnk;
  assign opaque = in2 & (rom_data != TRANSP_RGB);
  assign hit    = opaque & ~blank2;

  assign vga_out.hcount = s2.hcount;
  assign vga_out.vcount = s2.vcount;
  assign vga_out.hsync  = s2.hsync;
  assign vga_out.vsync  = s2.vsync;
  assign vga_out.hblnk  = s2.hblnk;
  assign vga_out.vblnk  = s2.vblnk;
  assign vga_out.rgb    = blank2 ? 12'h000 : (opaque ? rom_data : s2.rgb);
endmodule

// File: tb/tb_draw_sprite_anim.sv
// Directed bench for draw_sprite_anim: scale-1 instance A and scale-2 instance B share one input stream.
module tb_draw_sprite_anim;
  localparam int AW = 13;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_if vin();
  vga_if vout_a();
  vga_if vout_b();

  logic [11:0]   xpos, ypos;
  logic          mirror, anim_en;
  logic [AW-1:0] addr_a, addr_b;
  logic [11:0]   romd_a, romd_b;
  logic          hit_a, hit_b;
  logic [FW-1:0] fidx_a, fidx_b;
  int            rom_mode;
  int            checks = 0;
  int            failures = 0;

  draw_sprite_anim dut_a (
    .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout_a),
    .xpos(xpos), .ypos(ypos), .mirror(mirror), .anim_en(anim_en),
    .rom_addr(addr_a), .rom_data(romd_a), .hit(hit_a), .frame_idx(fidx_a));

  draw_sprite_anim #(.SCALE_LOG2(1), .FRAME_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout_b),
    .xpos(xpos), .ypos(ypos), .mirror(mirror), .anim_en(anim_en),
    .rom_addr(addr_b), .rom_data(romd_b), .hit(hit_b), .frame_idx(fidx_b));

  // ROM image: 0 = solid green, 1 = pixel (0,0) keyed, 2 = column 0 red / rest blue
  function automatic logic [11:0] rom_fn(input logic [AW-1:0] a);
    int p;
    p = int'(a) % 1536;
    case (rom_mode)
      1:       return (p == 0) ? 12'hF0F : 12'h0F0;
      2:       return (p % 32 == 0) ? 12'hF00 : 12'h00F;
      default: return 12'h0F0;
    endcase
  endfunction

  always @(posedge clk) begin
    romd_a <= rom_fn(addr_a);
    romd_b <= rom_fn(addr_b);
  end

  typedef struct {
    int          mode;
    int          h;
    int          v;
    logic        hb;
    logic [11:0] rgb;
    logic [11:0] exp_rgb;
    logic        exp_hit;
    int          exp_addr;
  } vec_t;
  vec_t tbl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.rgb    = rgb;
  endtask

  task automatic probe(input int h, input int v, input logic [11:0] rgb);
    set_in(h, v, 1'b0, 1'b0, rgb);
    tick(); tick(); tick();
  endtask

  task automatic vpulse();
    set_in(0, 0, 1'b1, 1'b0, 12'h000); tick();
    set_in(0, 0, 1'b1, 1'b1, 12'h000); tick();
    set_in(0, 0, 1'b1, 1'b0, 12'h000); tick();
  endtask

  task automatic chk_a(input string name, input logic [11:0] rgb, input logic h);
    check({name, "_a_rgb"}, 32'(vout_a.rgb), 32'(rgb));
    check({name, "_a_hit"}, 32'(hit_a), 32'(h));
  endtask

  task automatic chk_b(input string name, input logic [11:0] rgb, input logic h);
    check({name, "_b_rgb"}, 32'(vout_b.rgb), 32'(rgb));
    check({name, "_b_hit"}, 32'(hit_b), 32'(h));
  endtask

  initial begin
    tbl[0]  = '{0,   99, 50, 1'b0, 12'h123, 12'h123, 1'b0, -1};
    tbl[1]  = '{0,  100, 50, 1'b0, 12'h123, 12'h0F0, 1'b1, 0};
    tbl[2]  = '{0,  131, 50, 1'b0, 12'h123, 12'h0F0, 1'b1, 31};
    tbl[3]  = '{0,  132, 50, 1'b0, 12'h123, 12'h123, 1'b0, -1};
    tbl[4]  = '{0,  100, 49, 1'b0, 12'h123, 12'h123, 1'b0, -1};
    tbl[5]  = '{0,  131, 97, 1'b0, 12'h123, 12'h0F0, 1'b1, 1535};
    tbl[6]  = '{0,  100, 98, 1'b0, 12'h123, 12'h123, 1'b0, -1};
    tbl[7]  = '{0,  105, 52, 1'b0, 12'h123, 12'h0F0, 1'b1, 69};
    tbl[8]  = '{0,  115, 70, 1'b1, 12'h123, 12'h000, 1'b0, 655};
    tbl[9]  = '{0,    0,  0, 1'b0, 12'h456, 12'h456, 1'b0, -1};
    tbl[10] = '{1,  100, 50, 1'b0, 12'h123, 12'h123, 1'b0, 0};
    tbl[11] = '{1,  101, 50, 1'b0, 12'h123, 12'h0F0, 1'b1, 1};
    tbl[12] = '{2,  100, 50, 1'b0, 12'h123, 12'hF00, 1'b1, 0};
    tbl[13] = '{2,  131, 50, 1'b0, 12'h123, 12'h00F, 1'b1, 31};
    tbl[14] = '{0, 2047, 1023, 1'b0, 12'hABC, 12'hABC, 1'b0, -1};
    tbl[15] = '{1,  100, 97, 1'b0, 12'h123, 12'h0F0, 1'b1, 1504};

    rom_mode = 0;
    xpos = 12'd100; ypos = 12'd50; mirror = 1'b0; anim_en = 1'b0;
    set_in(77, 88, 1'b0, 1'b0, 12'h5A5);
    #12;
    check("rst_rgb", 32'(vout_a.rgb), 32'h0);
    check("rst_hcount", 32'(vout_a.hcount), 32'h0);
    check("rst_hit", 32'(hit_a), 32'h0);
    check("rst_addr", 32'(addr_a), 32'h0);
    check("rst_fidx", 32'(fidx_a), 32'h0);
    #2 rst = 1'b1;
    tick();

    vpulse();
    for (int i = 0; i < 16; i++) begin
      rom_mode = tbl[i].mode;
      set_in(tbl[i].h, tbl[i].v, tbl[i].hb, 1'b0, tbl[i].rgb);
      tick(); tick(); tick();
      check($sformatf("vec%0d_rgb", i), 32'(vout_a.rgb), 32'(tbl[i].exp_rgb));
      check($sformatf("vec%0d_hit", i), 32'(hit_a), 32'(tbl[i].exp_hit));
      check($sformatf("vec%0d_hc", i), 32'(vout_a.hcount), 32'(tbl[i].h));
      check($sformatf("vec%0d_vc", i), 32'(vout_a.vcount), 32'(tbl[i].v));
      if (tbl[i].exp_addr >= 0)
        check($sformatf("vec%0d_addr", i), 32'(addr_a), 32'(tbl[i].exp_addr));
    end

    // Mirror: red column lands at the right edge of both boxes
    rom_mode = 2; mirror = 1'b1; vpulse();
    probe(131, 50, 12'h123); chk_a("mir131", 12'hF00, 1'b1); chk_b("mir131", 12'h00F, 1'b1);
    probe(100, 50, 12'h123); chk_a("mir100", 12'h00F, 1'b1); chk_b("mir100", 12'h00F, 1'b1);
    probe(162, 50, 12'h123); chk_a("mir162", 12'h123, 1'b0); chk_b("mir162", 12'hF00, 1'b1);
    probe(163, 51, 12'h123); chk_b("mir163", 12'hF00, 1'b1);

    // Scale 2 box 64x96, each source pixel 2x2
    mirror = 1'b0; vpulse();
    probe(101, 51, 12'h123); chk_b("sc101", 12'hF00, 1'b1);
    probe(102, 50, 12'h123); chk_b("sc102", 12'h00F, 1'b1);
    probe(163, 145, 12'h123); chk_b("sc_corner", 12'h00F, 1'b1);
    check("sc_corner_addr", 32'(addr_b), 32'd1535);
    probe(164, 50, 12'h123); chk_b("sc164", 12'h123, 1'b0);
    probe(100, 146, 12'h123); chk_b("sc_v146", 12'h123, 1'b0);

    // Animation: A steps every 8 rising edges, B every edge
    rom_mode = 0; anim_en = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      vpulse();
      check($sformatf("anim%0d_a", n), 32'(fidx_a), 32'((n / 8) % 4));
      check($sformatf("anim%0d_b", n), 32'(fidx_b), 32'(n % 4));
      if (n == 16) begin
        probe(100, 50, 12'h123);
        check("anim16_addr", 32'(addr_a), 32'd3072);
      end
    end
    anim_en = 1'b0;
    for (int n = 0; n < 9; n++) vpulse();
    check("hold_a", 32'(fidx_a), 32'd1);
    check("hold_b", 32'(fidx_b), 32'd1);
    probe(100, 50, 12'h123);
    check("hold_addr", 32'(addr_a), 32'd1536);

    // Mid-frame xpos change waits for the next vblank
    ypos = 12'd180; vpulse();
    probe(100, 200, 12'h123); chk_a("mf_before", 12'h0F0, 1'b1);
    xpos = 12'd300;
    probe(100, 200, 12'h123); chk_a("mf_old", 12'h0F0, 1'b1);
    probe(300, 200, 12'h123); chk_a("mf_new_early", 12'h123, 1'b0);
    vpulse();
    probe(300, 200, 12'h123); chk_a("mf_new", 12'h0F0, 1'b1);
    probe(100, 200, 12'h123); chk_a("mf_old_gone", 12'h123, 1'b0);

    // Asynchronous reset mid-line
    set_in(300, 200, 1'b0, 1'b0, 12'h123);
    #2 rst = 1'b0;
    #1;
    check("arst_rgb", 32'(vout_a.rgb), 32'h0);
    check("arst_hcount", 32'(vout_a.hcount), 32'h0);
    check("arst_vcount", 32'(vout_a.vcount), 32'h0);
    check("arst_hit", 32'(hit_a), 32'h0);
    check("arst_addr", 32'(addr_a), 32'h0);
    check("arst_fidx", 32'(fidx_a), 32'h0);
    tick(); tick(); tick();
    check("arst_hold_hc", 32'(vout_a.hcount), 32'h0);
    #2 rst = 1'b1;
    tick();

    // Exactly two cycles of latency on every field
    for (int k = 0; k < 6; k++) begin
      set_in(600 + k, 300, 1'b0, 1'b0, 12'(12'h100 + k));
      vin.hsync = k[0];
      tick();
      if (k >= 1) begin
        check($sformatf("lat%0d_hc", k), 32'(vout_a.hcount), 32'(600 + k - 1));
        check($sformatf("lat%0d_rgb", k), 32'(vout_a.rgb), 32'(12'h100 + k - 1));
        check($sformatf("lat%0d_hs", k), 32'(vout_a.hsync), 32'((k - 1) % 2));
      end
    end
    check("post_rst_fidx", 32'(fidx_a), 32'h0);
    probe(10, 10, 12'h123); chk_a("post_rst_origin", 12'h0F0, 1'b1);
    probe(40, 10, 12'h123); chk_a("post_rst_out", 12'h123, 1'b0);

    // Right-edge clipping: no wrap into the left columns
    xpos = 12'd4080; ypos = 12'd0; vpulse();
    probe(0, 10, 12'h123);  chk_a("clip4080_h0", 12'h123, 1'b0);
    probe(15, 10, 12'h123); chk_a("clip4080_h15", 12'h123, 1'b0);
    xpos = 12'd2040; vpulse();
    probe(2040, 10, 12'h123); chk_a("clip2040_l", 12'h0F0, 1'b1);
    probe(2047, 10, 12'h123); chk_a("clip2040_r", 12'h0F0, 1'b1);
    check("clip2040_addr", 32'(addr_a), 32'd327);
    probe(2039, 10, 12'h123); chk_a("clip2040_out", 12'h123, 1'b0);
    probe(7, 10, 12'h123);    chk_a("clip2040_nowrap", 12'h123, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
